// File: rtl/booth_r8_pkg.sv
// Shared types and radix-8 Booth helpers for the shared-multiplicand MAC engine.
package booth_r8_pkg;

    typedef enum logic [1:0] {
        MODE_INT8 = 2'b00,
        MODE_BF16 = 2'b01,
        MODE_FP16 = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRECOMP = 2'b01,
        ITER    = 2'b10,
        DONE    = 2'b11
    } state_e;

    // Multiples table slot k holds (k - MULT_ZERO) * B, so slots 0..8 cover -4B .. +4B.
    localparam int NUM_MULTS = 9;
    localparam int MULT_ZERO = 4;
    localparam int DIGIT_W   = 3;

    typedef struct packed {
        logic       neg;
        logic [2:0] mag;
    } booth_digit_t;

    function automatic logic [DIGIT_W-1:0] nd_of(input mode_e m);
        return (m == MODE_FP16) ? 3'd4 : 3'd3;
    endfunction

    // Window is {a[3j+2], a[3j+1], a[3j], a[3j-1]}.
    function automatic booth_digit_t booth_digit(input logic [3:0] win);
        booth_digit_t d;
        case (win)
            4'b0001, 4'b0010: d = '{neg: 1'b0, mag: 3'd1};
            4'b0011, 4'b0100: d = '{neg: 1'b0, mag: 3'd2};
            4'b0101, 4'b0110: d = '{neg: 1'b0, mag: 3'd3};
            4'b0111:          d = '{neg: 1'b0, mag: 3'd4};
            4'b1000:          d = '{neg: 1'b1, mag: 3'd4};
            4'b1001, 4'b1010: d = '{neg: 1'b1, mag: 3'd3};
            4'b1011, 4'b1100: d = '{neg: 1'b1, mag: 3'd2};
            4'b1101, 4'b1110: d = '{neg: 1'b1, mag: 3'd1};
            default:          d = '{neg: 1'b0, mag: 3'd0};
        endcase
        return d;
    endfunction

    function automatic logic [3:0] mult_slot(input booth_digit_t d);
        return d.neg ? (4'(MULT_ZERO) - {1'b0, d.mag})
                     : (4'(MULT_ZERO) + {1'b0, d.mag});
    endfunction

endpackage

// File: rtl/booth_r8_lane_select.sv
// Per-lane Booth digit decode and partial-product selection from the shared multiples table.
module booth_r8_lane_select
    import booth_r8_pkg::*;
#(
    parameter int OPW   = 12,
    parameter int ACC_W = 32,
    parameter int MW    = OPW + 3
) (
    input  logic [NUM_MULTS-1:0][MW-1:0] i_mults,
    input  logic [OPW-1:0]               i_a,
    input  logic [DIGIT_W-1:0]           i_digit,
    output logic [ACC_W-1:0]             o_pp
);

    logic signed [OPW:0] w_a_pad;
    logic [5:0]          w_shift;
    logic [3:0]          w_win;
    booth_digit_t        w_digit;
    logic [MW-1:0]       w_mult;
    logic [ACC_W-1:0]    w_mult_sx;

    assign w_shift = {2'b00, i_digit, 1'b0} + {3'b000, i_digit};

    // The appended zero is a[-1]; the arithmetic shift makes bits past the top read as the sign.
    assign w_a_pad = {i_a, 1'b0};
    assign w_win   = 4'(w_a_pad >>> w_shift);

    assign w_digit   = booth_digit(w_win);
    assign w_mult    = i_mults[mult_slot(w_digit)];
    assign w_mult_sx = {{(ACC_W-MW){w_mult[MW-1]}}, w_mult};
    assign o_pp      = w_mult_sx << w_shift;

endmodule

// File: rtl/booth_r8_shared_mac.sv
// Multi-cycle radix-8 Booth MAC: one shared multiplicand, LANES multipliers, per-lane accumulators.
module booth_r8_shared_mac
    import booth_r8_pkg::*;
#(
    parameter int LANES = 16,
    parameter int OPW   = 12,
    parameter int ACC_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic                   acc_en,
    input  logic [OPW-1:0]         b_data,
    input  logic [LANES*OPW-1:0]   a_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] out_data
);

    localparam int MW = OPW + 3;

    function automatic logic [OPW-1:0] extend_op(input mode_e m, input logic [OPW-1:0] raw);
        logic [OPW-1:0] v;
        case (m)
            MODE_BF16: v = {{(OPW-8){1'b0}}, raw[7:0]};
            MODE_FP16: v = {{(OPW-11){1'b0}}, raw[10:0]};
            default:   v = {{(OPW-8){raw[7]}}, raw[7:0]};
        endcase
        return v;
    endfunction

    state_e                        r_state;
    mode_e                         r_mode;
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic                          r_acc_en;
    logic [OPW-1:0]                r_b_op;
    logic [LANES-1:0][OPW-1:0]     r_a_op;
    logic [NUM_MULTS-1:0][MW-1:0]  r_mults;
    logic [DIGIT_W-1:0]            r_digit;
    logic [LANES-1:0][ACC_W-1:0]   r_sum;
    logic [LANES-1:0][ACC_W-1:0]   r_out_data;

    mode_e                         w_mode_in;
    logic [LANES-1:0][OPW-1:0]     w_a_in;
    logic [LANES-1:0][OPW-1:0]     w_a_ext;
    logic [OPW-1:0]                w_b_ext;
    logic [NUM_MULTS-1:0][MW-1:0]  w_mults;
    logic [LANES-1:0][ACC_W-1:0]   w_pp;
    logic [LANES-1:0][ACC_W-1:0]   w_sum_next;
    logic                          w_accept;
    logic                          w_last_digit;
    logic                          w_unused_hi;

    assign w_mode_in    = mode_e'(mode);
    assign w_a_in       = a_data;
    assign w_b_ext      = extend_op(w_mode_in, b_data);
    assign w_accept     = in_valid && r_in_ready;
    assign w_last_digit = (r_digit == (nd_of(r_mode) - 3'd1));

    always_comb begin
        w_a_ext = '0;
        for (int i = 0; i < LANES; i++) begin
            w_a_ext[i] = extend_op(w_mode_in, w_a_in[i]);
        end
    end

    // Operand bits above the FP16 mantissa never reach the datapath in any mode.
    always_comb begin
        w_unused_hi = ^b_data[OPW-1:11];
        for (int i = 0; i < LANES; i++) begin
            w_unused_hi = w_unused_hi ^ (^w_a_in[i][OPW-1:11]);
        end
    end

    always_comb begin
        logic [MW-1:0] b1, b2, b3, b4;
        b1 = {{3{r_b_op[OPW-1]}}, r_b_op};
        b2 = b1 << 1;
        b3 = b1 + b2;
        b4 = b1 << 2;
        w_mults              = '0;
        w_mults[MULT_ZERO+1] = b1;
        w_mults[MULT_ZERO+2] = b2;
        w_mults[MULT_ZERO+3] = b3;
        w_mults[MULT_ZERO+4] = b4;
        w_mults[MULT_ZERO-1] = -b1;
        w_mults[MULT_ZERO-2] = -b2;
        w_mults[MULT_ZERO-3] = -b3;
        w_mults[MULT_ZERO-4] = -b4;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        booth_r8_lane_select #(
            .OPW   (OPW),
            .ACC_W (ACC_W),
            .MW    (MW)
        ) u_sel (
            .i_mults (r_mults),
            .i_a     (r_a_op[g]),
            .i_digit (r_digit),
            .o_pp    (w_pp[g])
        );
        assign w_sum_next[g] = r_sum[g] + w_pp[g];
    end

    // NOTE: every register in this block uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the wide lane arrays are reset too, since out_data must read zero after reset.
            r_state     <= IDLE;
            r_mode      <= MODE_INT8;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_acc_en    <= 1'b0;
            r_b_op      <= '0;
            r_a_op      <= '0;
            r_mults     <= '0;
            r_digit     <= '0;
            r_sum       <= '0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_a_op     <= w_a_ext;
                        r_b_op     <= w_b_ext;
                        r_mode     <= w_mode_in;
                        r_acc_en   <= acc_en;
                        r_in_ready <= 1'b0;
                        r_state    <= PRECOMP;
                    end
                end
                PRECOMP: begin
                    r_mults <= w_mults;
                    r_digit <= '0;
                    r_sum   <= r_acc_en ? r_out_data : '0;
                    r_state <= ITER;
                end
                ITER: begin
                    r_sum   <= w_sum_next;
                    r_digit <= r_digit + DIGIT_W'(1);
                    if (w_last_digit) begin
                        r_out_data  <= w_sum_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_booth_r8_shared_mac.sv
// Self-checking bench: directed cases plus randomized traffic against a cycle-level behavioural model.
module tb_booth_r8_shared_mac;

    localparam int LANES    = 16;
    localparam int OPW      = 12;
    localparam int ACC_W    = 32;
    localparam int DW       = LANES * ACC_W;
    localparam int AW       = LANES * OPW;
    localparam int N_RANDOM = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    mode = 2'b00;
    logic          acc_en = 1'b0;
    logic [OPW-1:0] b_data = '0;
    logic [AW-1:0] a_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_r8_shared_mac #(
        .LANES (LANES),
        .OPW   (OPW),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .acc_en    (acc_en),
        .b_data    (b_data),
        .a_data    (a_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Value of an operand as the mode defines it: signed byte, unsigned byte or 11-bit mantissa.
    function automatic longint ext_val(input logic [1:0] m, input logic [OPW-1:0] raw);
        case (m)
            2'b01:   return longint'(raw[7:0]);
            2'b10:   return longint'(raw[10:0]);
            default: return longint'($signed(raw[7:0]));
        endcase
    endfunction

    // Behavioural model: busy/ready timing from the latency rules, results from plain arithmetic.
    logic [ACC_W-1:0] m_held [LANES];
    logic [ACC_W-1:0] m_pend [LANES];
    bit m_live      = 1'b0;
    bit m_ready_exp = 1'b0;
    bit m_valid_exp = 1'b0;
    int m_countdown = 0;
    int m_accepts   = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live      = 1'b1;
            m_ready_exp = 1'b0;
            m_valid_exp = 1'b0;
            m_countdown = 0;
            for (int i = 0; i < LANES; i++) m_held[i] = '0;
        end else if (m_live) begin
            if (m_valid_exp) begin
                if (out_ready) begin
                    m_valid_exp = 1'b0;
                    m_ready_exp = 1'b1;
                end
            end else if (m_countdown > 0) begin
                m_countdown--;
                if (m_countdown == 0) begin
                    m_valid_exp = 1'b1;
                    for (int i = 0; i < LANES; i++) m_held[i] = m_pend[i];
                end
            end else if (!m_ready_exp) begin
                m_ready_exp = 1'b1;
            end else if (in_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    longint ea, eb;
                    ea = ext_val(mode, a_data[i*OPW +: OPW]);
                    eb = ext_val(mode, b_data);
                    m_pend[i] = (acc_en ? m_held[i] : 32'd0) + ACC_W'(ea * eb);
                end
                m_ready_exp = 1'b0;
                m_countdown = (mode == 2'b10) ? 5 : 4;
                m_accepts++;
            end
        end
    end

    always @(negedge clk) begin
        logic [DW-1:0] exp_vec;
        if (m_live) begin
            for (int i = 0; i < LANES; i++) exp_vec[i*ACC_W +: ACC_W] = m_held[i];
            check("model_in_ready", DW'(in_ready), DW'(m_ready_exp));
            check("model_out_valid", DW'(out_valid), DW'(m_valid_exp));
            check("model_out_data", out_data, exp_vec);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [OPW-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 12'h7FF;
            1:       return 12'h080;
            2:       return 12'hFFF;
            3:       return 12'h000;
            default: return OPW'($urandom);
        endcase
    endfunction

    function automatic logic [AW-1:0] rand_vec();
        logic [AW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*OPW +: OPW] = rand_op();
        return v;
    endfunction

    function automatic logic [AW-1:0] with_lane(input logic [AW-1:0] v, input int l, input logic [OPW-1:0] x);
        logic [AW-1:0] r;
        r = v;
        r[l*OPW +: OPW] = x;
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] lane_of(input int l);
        return out_data[l*ACC_W +: ACC_W];
    endfunction

    // Holds in_valid until the engine is seen ready; returns just after the accepting edge.
    task automatic send(input logic [1:0] md, input logic ae, input logic [OPW-1:0] b, input logic [AW-1:0] a);
        bit got;
        mode = md; acc_en = ae; b_data = b; a_data = a; in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        check("send_ready_seen", DW'(got), DW'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic await_result(input int exp_lat, input string name);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check(name, DW'(lat), DW'(exp_lat));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int start_accepts;

    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        rst = 1'b0;
        tick();
        check("ready_after_rst", DW'(in_ready), DW'(1));

        // FP16 full-scale mantissas
        send(2'b10, 1'b0, 12'h7FF, with_lane(rand_vec(), 0, 12'h7FF));
        await_result(5, "fp16_latency");
        release_result();
        check("fp16_lane0", DW'(lane_of(0)), DW'(32'h003F_F001));

        // INT8 most-negative times most-positive, upper bits set then clear (reserved mode = INT8)
        send(2'b00, 1'b0, 12'hF7F, with_lane(rand_vec(), 3, 12'hF80));
        await_result(4, "int8_latency");
        release_result();
        check("int8_lane3_upper", DW'(lane_of(3)), DW'(32'hFFFF_C080));
        send(2'b11, 1'b0, 12'h07F, with_lane(rand_vec(), 3, 12'h080));
        await_result(4, "rsvd_latency");
        release_result();
        check("rsvd_lane3", DW'(lane_of(3)), DW'(32'hFFFF_C080));

        // Accumulation chain on lane 0
        send(2'b00, 1'b0, 12'h005, with_lane(rand_vec(), 0, 12'h003));
        await_result(4, "acc1_latency");
        release_result();
        check("acc1_lane0", DW'(lane_of(0)), DW'(32'd15));
        send(2'b00, 1'b1, 12'h004, with_lane(rand_vec(), 0, 12'h0FE));
        await_result(4, "acc2_latency");
        release_result();
        check("acc2_lane0", DW'(lane_of(0)), DW'(32'd7));
        send(2'b00, 1'b0, 12'h0FD, with_lane(rand_vec(), 0, 12'h007));
        await_result(4, "acc3_latency");
        release_result();
        check("acc3_lane0", DW'(lane_of(0)), DW'(32'hFFFF_FFEB));

        // BF16 unsigned bytes
        send(2'b01, 1'b0, 12'h0FF, with_lane(rand_vec(), 5, 12'h0FF));
        await_result(4, "bf16_latency");
        release_result();
        check("bf16_lane5", DW'(lane_of(5)), DW'(32'd65025));

        // Backpressure in DONE with an ignored request pulse
        send(2'b00, 1'b1, rand_op(), rand_vec());
        await_result(4, "bp_latency");
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready", DW'(in_ready), DW'(0));
            check("bp_out_valid", DW'(out_valid), DW'(1));
            in_valid = (k == 1);
            b_data   = rand_op();
            a_data   = rand_vec();
            tick();
        end
        in_valid = 1'b0;
        release_result();
        check("bp_valid_drop", DW'(out_valid), DW'(0));
        check("bp_idle_ready", DW'(in_ready), DW'(1));
        send(2'b10, 1'b1, rand_op(), rand_vec());
        await_result(5, "bp_next_latency");
        release_result();

        // Reset during the second digit discards the operation and clears held results
        send(2'b00, 1'b0, 12'h009, with_lane(rand_vec(), 0, 12'h009));
        await_result(4, "pre_rst_latency");
        release_result();
        check("pre_rst_lane0", DW'(lane_of(0)), DW'(32'd81));
        send(2'b00, 1'b1, rand_op(), rand_vec());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", DW'(out_valid), DW'(0));
        check("midrst_out_data", out_data, DW'(0));
        check("midrst_in_ready", DW'(in_ready), DW'(0));
        send(2'b00, 1'b1, 12'h005, with_lane('0, 0, 12'h003));
        await_result(4, "postrst_latency");
        release_result();
        check("postrst_data", out_data, DW'(32'd15));

        // Randomized traffic: requests, modes, accumulate and output backpressure all random
        start_accepts = m_accepts;
        for (int cyc = 0; cyc < 40000 && (m_accepts - start_accepts) < N_RANDOM; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            mode      = 2'($urandom);
            acc_en    = 1'($urandom);
            b_data    = rand_op();
            a_data    = rand_vec();
            out_ready = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        out_ready = 1'b0;
        check("random_requests", DW'(m_accepts - start_accepts), DW'(N_RANDOM));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_r8_shared_mac.md
Name: booth_r8_shared_mac

Overview:
- Multi-cycle radix-8 Booth multiply-accumulate engine for the FP16/BF16/INT8 TMUL datapath.
- One shared multiplicand B feeds LANES lanes, one per element of a row of A.
- The signed multiples table {0, ±1, ±2, ±3, ±4}×B is built once per operation and shared by all lanes.
- Each lane Booth-decodes its own A operand, 3 bits per cycle, and accumulates the partial products.
- Handles mantissa/integer products only. Exponent and sign logic stays with the caller.

Parameters:
- LANES, 16, number of parallel lanes sharing one multiples table.
- OPW, 12, internal signed operand width. Must be ≥12 to hold an extended FP16 mantissa.
- ACC_W, 32, per-lane accumulator width. Must be ≥2*OPW.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  engine can accept a request.
- mode  in  2  operand format: 00 INT8, 01 BF16, 10 FP16, 11 reserved (treated as INT8).
- acc_en  in  1  1 = add the product to the lane's held result; 0 = overwrite it.
- b_data  in  OPW  shared multiplicand.
- a_data  in  LANES*OPW  per-lane multipliers, packed [LANES-1:0][OPW-1:0].
- out_valid  out  1  results available.
- out_ready  in  1  consumer accepts the results.
- out_data  out  LANES*ACC_W  per-lane accumulators, two's complement.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - in_ready=0 during the reset cycle, 1 in the first cycle after.
  - out_valid=0, out_data=0, all internal registers cleared.
  - Reset overrides everything, including mid-operation. An in-flight operation is discarded with no output.
- Operand extension, applied to both A and B when the request is accepted:
  - INT8: bits[7:0] sign-extended.
  - BF16: bits[7:0] zero-extended.
  - FP16: bits[10:0] zero-extended.
  - Unused upper bits are ignored.
- Digit count ND: 3 for INT8 and BF16, 4 for FP16.
- Digit decode:
  - Digit j = -4·a[3j+2] + 2·a[3j+1] + a[3j] + a[3j-1], with a[-1]=0.
  - Bits above OPW-1 read as the sign bit.
  - Digits are processed LSB first; the partial product for digit j is shifted left by 3j.
- FSM:
  - IDLE: in_ready=1. When in_valid=1, register the extended operands, mode and acc_en, then go to PRECOMP.
  - PRECOMP (1 cycle): register the multiples table, including the hard multiple 3B = B + 2B. Digit counter = 0. Each lane's working sum is loaded with its held result if acc_en=1, otherwise 0. Go to ITER.
  - ITER: each cycle, every lane adds its sign-extended, shifted selected multiple to its working sum; the counter increments. After digit ND-1, copy working sums to out_data, set out_valid=1 and go to DONE.
  - DONE: out_valid=1 and out_data held stable. in_ready=0. When out_ready=1, out_valid drops next cycle and the state returns to IDLE.
- Throughput: DONE→IDLE takes a full cycle, so a new request is never accepted in the same cycle as the output handshake.
- Latency: out_valid goes high ND+1 cycles after the accept edge (INT8/BF16: 4, FP16: 5).
- Arithmetic: all sums are modulo 2^ACC_W (wrap-around), with no saturation and no overflow flag.
- Input/output coupling: in_valid while busy is ignored, not queued. out_ready outside DONE is ignored.
- Held results persist across operations until reset or an operation with acc_en=0.

Decomposition:
- Package booth_r8_pkg holds:
  - mode_e (MODE_INT8, MODE_BF16, MODE_FP16, MODE_RSVD).
  - state_e (IDLE, PRECOMP, ITER, DONE).
  - Function nd_of(mode_e) returning the digit count.
  - Function booth_digit(4-bit window) returning a 3-bit magnitude plus a negate flag.
- Sub-module booth_r8_lane_select: combinational, one instance per lane.
  - Inputs: the shared multiples table, the lane operand, the digit index.
  - Output: the sign-extended, shifted partial product (ACC_W bits).

Test Plan:
- FP16: A lane0=0x7FF, B=0x7FF, acc_en=0 → out_valid 5 cycles after accept; lane0 = 0x003FF001 (4190209).
- INT8: A lane3=0x80, B=0x7F → out_valid 4 cycles after accept; lane3 = 0xFFFFC080 (-16256). Upper input bits set to 1 must not change the result.
- Accumulate, INT8, lane0:
  - Operation 1: A=3, B=5, acc_en=0 → 15.
  - Operation 2: A=0xFE, B=4, acc_en=1 → 7.
  - Operation 3: acc_en=0 → plain product.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → out_data stable, in_ready=0, and an in_valid pulse is ignored. Raise out_ready → IDLE next cycle, then a new request is accepted.
- Reset mid-ITER (2nd digit) → next cycle state IDLE, out_valid=0, out_data=0. A following acc_en=1 operation accumulates from 0.
- All lanes random, all modes, 1000 requests → each lane equals the reference signed product (plus the held value when acc_en=1) mod 2^32.
